// File: rtl/snake_pkg.sv
// Shared screen geometry, colour constants and scheduler state encoding
// for the snake game video path.
package snake_pkg;

   localparam int SCREEN_W = 160;
   localparam int SCREEN_H = 120;

   localparam logic [2:0] COL_BLACK = 3'b000;
   localparam logic [2:0] COL_RED   = 3'b100;
   localparam logic [2:0] COL_WHITE = 3'b111;

   typedef enum logic {
      ST_SERVE = 1'b0,
      ST_CLEAR = 1'b1
   } state_t;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: first valid requester at or after rr_ptr
// (modulo NUM_REQ) wins; one-hot grant plus its index.
module rr_arbiter #(
   parameter int NUM_REQ = 2,
   parameter int IDX_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
   input  logic [NUM_REQ-1:0] req_valid,
   input  logic [IDX_W-1:0]   rr_ptr,
   output logic [NUM_REQ-1:0] grant,
   output logic [IDX_W-1:0]   grant_idx
);

   logic             found;
   logic [IDX_W-1:0] idx;

   always_comb begin
      grant     = '0;
      grant_idx = '0;
      found     = 1'b0;
      idx       = '0;
      for (int k = 0; k < NUM_REQ; k++) begin
         idx = IDX_W'((int'(rr_ptr) + k) % NUM_REQ);
         if (!found && req_valid[idx]) begin
            found      = 1'b1;
            grant[idx] = 1'b1;
            grant_idx  = idx;
         end
      end
   end

endmodule

// File: rtl/plot_scheduler.sv
// Shares the VGA adapter write port between pixel requesters and sweeps the
// whole screen with CLEAR_COLOUR on request.
//
//   state    | meaning
//   ---------+-----------------------------------------------------------
//   ST_SERVE | round-robin arbitration of requesters into the VGA port
//   ST_CLEAR | one clear pixel per cycle, raster order, requesters stalled
module plot_scheduler
   import snake_pkg::*;
#(
   parameter int         NUM_REQ      = 2,
   parameter int         X_MAX        = SCREEN_W,
   parameter int         Y_MAX        = SCREEN_H,
   parameter logic [2:0] CLEAR_COLOUR = COL_BLACK
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic                   clear_start,
   output logic                   clear_busy,
   output logic                   clear_done,
   input  logic [NUM_REQ-1:0]     req_valid,
   input  logic [8*NUM_REQ-1:0]   req_x,
   input  logic [7*NUM_REQ-1:0]   req_y,
   input  logic [3*NUM_REQ-1:0]   req_colour,
   output logic [NUM_REQ-1:0]     req_ready,
   output logic [7:0]             vga_x,
   output logic [6:0]             vga_y,
   output logic [2:0]             vga_colour,
   output logic                   vga_plot
);

   localparam int         IDX_W    = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
   localparam logic [7:0] X_LIM    = 8'(X_MAX);
   localparam logic [6:0] Y_LIM    = 7'(Y_MAX);
   localparam logic [7:0] X_END    = 8'(X_MAX - 1);
   localparam logic [6:0] Y_END    = 7'(Y_MAX - 1);
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_REQ - 1);

   state_t             state;
   logic [IDX_W-1:0]   rr_ptr;
   logic [7:0]         cx;
   logic [6:0]         cy;

   logic [NUM_REQ-1:0] grant;
   logic [IDX_W-1:0]   grant_idx;
   logic [7:0]         gx;
   logic [6:0]         gy;
   logic [2:0]         gc;
   logic               xfer;
   logic               in_range;

   rr_arbiter #(
      .NUM_REQ (NUM_REQ),
      .IDX_W   (IDX_W)
   ) u_arb (
      .req_valid (req_valid),
      .rr_ptr    (rr_ptr),
      .grant     (grant),
      .grant_idx (grant_idx)
   );

   // clear_start wins over pending requests in the same cycle
   assign req_ready = (state == ST_SERVE && !clear_start && !reset) ? grant : '0;
   assign xfer      = |req_ready;

   always_comb begin
      gx = '0;
      gy = '0;
      gc = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
         if (grant[i]) begin
            gx = req_x[8*i +: 8];
            gy = req_y[7*i +: 7];
            gc = req_colour[3*i +: 3];
         end
      end
   end

   assign in_range = (gx < X_LIM) && (gy < Y_LIM);

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state      <= ST_SERVE;
         rr_ptr     <= '0;
         cx         <= '0;
         cy         <= '0;
         vga_x      <= '0;
         vga_y      <= '0;
         vga_colour <= '0;
         vga_plot   <= 1'b0;
         clear_busy <= 1'b0;
         clear_done <= 1'b0;
      end else begin
         vga_plot   <= 1'b0;
         clear_done <= 1'b0;
         case (state)
            ST_SERVE: begin
               if (clear_start) begin
                  state      <= ST_CLEAR;
                  cx         <= '0;
                  cy         <= '0;
                  clear_busy <= 1'b1;
               end else if (xfer) begin
                  rr_ptr <= (grant_idx == LAST_IDX) ? '0 : grant_idx + 1'b1;
                  // out-of-range pixels are consumed but never reach the adapter
                  if (in_range) begin
                     vga_x      <= gx;
                     vga_y      <= gy;
                     vga_colour <= gc;
                     vga_plot   <= 1'b1;
                  end
               end
            end
            ST_CLEAR: begin
               vga_x      <= cx;
               vga_y      <= cy;
               vga_colour <= CLEAR_COLOUR;
               vga_plot   <= 1'b1;
               if (cx == X_END) begin
                  cx <= '0;
                  if (cy == Y_END) begin
                     cy         <= '0;
                     state      <= ST_SERVE;
                     clear_busy <= 1'b0;
                     clear_done <= 1'b1;
                  end else begin
                     cy <= cy + 1'b1;
                  end
               end else begin
                  cx <= cx + 1'b1;
               end
            end
            default: state <= ST_SERVE;
         endcase
      end
   end

endmodule

// File: tb/tb_plot_scheduler.sv
// Randomized and directed checks of plot_scheduler against a pixel-level
// reference model (request queue arbitration and a linear clear index).
module tb_plot_scheduler;

   localparam int NR = 2;
   localparam int XM = 160;
   localparam int YM = 120;
   localparam int NPIX = XM * YM;

   logic          clk = 1'b0;
   logic          reset;
   logic          clear_start;
   logic          clear_busy;
   logic          clear_done;
   logic [NR-1:0] req_valid;
   logic [8*NR-1:0] req_x;
   logic [7*NR-1:0] req_y;
   logic [3*NR-1:0] req_colour;
   logic [NR-1:0] req_ready;
   logic [7:0]    vga_x;
   logic [6:0]    vga_y;
   logic [2:0]    vga_colour;
   logic          vga_plot;

   always #5 clk = ~clk;

   plot_scheduler dut (
      .clk         (clk),
      .reset       (reset),
      .clear_start (clear_start),
      .clear_busy  (clear_busy),
      .clear_done  (clear_done),
      .req_valid   (req_valid),
      .req_x       (req_x),
      .req_y       (req_y),
      .req_colour  (req_colour),
      .req_ready   (req_ready),
      .vga_x       (vga_x),
      .vga_y       (vga_y),
      .vga_colour  (vga_colour),
      .vga_plot    (vga_plot)
   );

   int n_cmp = 0;
   int n_bad = 0;

   // stimulus state
   bit v[NR];
   int px[NR], py[NR], pc[NR];
   bit cs;

   // reference model state
   int m_rr, m_n;
   bit m_clear;
   int e_x, e_y, e_c, e_plot, e_busy, e_done;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
      end
   endtask

   task automatic drive();
      for (int i = 0; i < NR; i++) begin
         req_valid[i]          = v[i];
         req_x[8*i +: 8]       = 8'(px[i]);
         req_y[7*i +: 7]       = 7'(py[i]);
         req_colour[3*i +: 3]  = 3'(pc[i]);
      end
      clear_start = cs;
   endtask

   task automatic model_reset();
      m_rr = 0; m_n = 0; m_clear = 0;
      e_x = 0; e_y = 0; e_c = 0; e_plot = 0; e_busy = 0; e_done = 0;
   endtask

   function automatic int model_grant();
      if (m_clear || cs) return -1;
      for (int k = 0; k < NR; k++) begin
         if (v[(m_rr + k) % NR]) return (m_rr + k) % NR;
      end
      return -1;
   endfunction

   task automatic model_edge(input int g);
      e_plot = 0;
      e_done = 0;
      if (m_clear) begin
         e_x = m_n % XM; e_y = m_n / XM; e_c = 0; e_plot = 1;
         m_n++;
         if (m_n == NPIX) begin
            m_clear = 0; e_busy = 0; e_done = 1;
         end
      end else if (cs) begin
         m_clear = 1; m_n = 0; e_busy = 1;
      end else if (g >= 0) begin
         m_rr = (g + 1) % NR;
         if (px[g] < XM && py[g] < YM) begin
            e_x = px[g]; e_y = py[g]; e_c = pc[g]; e_plot = 1;
         end
      end
   endtask

   // one clock: inputs applied now, ready checked mid-cycle, outputs after the edge
   task automatic cycle(output int g, output logic [NR-1:0] rdy);
      drive();
      @(negedge clk);
      g   = model_grant();
      rdy = req_ready;
      chk("ready", rdy, (g < 0) ? 0 : (1 << g));
      @(posedge clk);
      #1;
      model_edge(g);
      chk("plot",   vga_plot,   e_plot);
      chk("x",      vga_x,      e_x);
      chk("y",      vga_y,      e_y);
      chk("colour", vga_colour, e_c);
      chk("busy",   clear_busy, e_busy);
      chk("done",   clear_done, e_done);
   endtask

   task automatic new_req(input int i);
      v[i]  = ($urandom_range(0, 3) != 0);
      px[i] = ($urandom_range(0, 9) == 0) ? $urandom_range(160, 255) : $urandom_range(0, 159);
      py[i] = ($urandom_range(0, 9) == 0) ? $urandom_range(120, 127) : $urandom_range(0, 119);
      pc[i] = $urandom_range(0, 7);
   endtask

   task automatic random_run(input int n);
      int g;
      logic [NR-1:0] rdy;
      for (int c = 0; c < n; c++) begin
         cycle(g, rdy);
         for (int i = 0; i < NR; i++) begin
            if (i == g || !v[i]) new_req(i);
            else if ($urandom_range(0, 9) == 0) v[i] = 0;
         end
      end
   endtask

   task automatic set_req(input int i, input bit vv, input int x, input int y, input int c);
      v[i] = vv; px[i] = x; py[i] = y; pc[i] = c;
   endtask

   initial begin
      int g;
      logic [NR-1:0] rdy;
      int a, done_cnt, rdy_cnt;

      reset = 1'b1;
      cs = 0;
      for (int i = 0; i < NR; i++) set_req(i, 0, 0, 0, 0);
      drive();
      model_reset();
      #2;
      chk("rst_plot", vga_plot, 0);
      chk("rst_x", vga_x, 0);
      chk("rst_ready", req_ready, 0);
      repeat (2) @(posedge clk);
      #1 reset = 1'b0;

      random_run(300);

      // test 1: reset mid-stream with a pending request
      set_req(0, 1, 33, 44, 5);
      set_req(1, 1, 55, 66, 2);
      drive();
      @(negedge clk);
      #2 reset = 1'b1;
      #1;
      chk("mrst_plot",  vga_plot,   0);
      chk("mrst_x",     vga_x,      0);
      chk("mrst_y",     vga_y,      0);
      chk("mrst_col",   vga_colour, 0);
      chk("mrst_busy",  clear_busy, 0);
      chk("mrst_done",  clear_done, 0);
      chk("mrst_ready", req_ready,  0);
      @(posedge clk);
      #1 reset = 1'b0;
      model_reset();
      set_req(0, 1, 10, 20, 7);
      set_req(1, 0, 0, 0, 0);
      cycle(g, rdy);
      chk("t1_ready", rdy, 1);
      chk("t1_plot", vga_plot, 1);
      chk("t1_x", vga_x, 10);
      chk("t1_y", vga_y, 20);
      chk("t1_col", vga_colour, 7);

      // test 2: both valid continuously, grants alternate starting at req1
      a = 1;
      set_req(0, 1, 1, 1, 1);
      set_req(1, 1, 100, 100, 6);
      for (int c = 0; c < 8; c++) begin
         cycle(g, rdy);
         chk("t2_alt", rdy, 1 << a);
         chk("t2_plot", vga_plot, 1);
         a ^= 1;
         if (g >= 0) set_req(g, 1, (px[g] + 7) % XM, (py[g] + 3) % YM, (pc[g] + 1) % 8);
      end

      // test 3: only req1 valid for three pixels, then rr_ptr must point at req0
      set_req(0, 0, 0, 0, 0);
      for (int c = 0; c < 3; c++) begin
         set_req(1, 1, 40 + c, 50 + c, c);
         cycle(g, rdy);
         chk("t3_grant", rdy, 2);
      end
      set_req(0, 1, 3, 4, 5);
      set_req(1, 1, 6, 7, 1);
      cycle(g, rdy);
      chk("t3_rrptr", rdy, 1);

      // test 4: clear_start while both requesters valid
      set_req(0, 1, 11, 12, 3);
      set_req(1, 1, 21, 22, 4);
      cs = 1;
      cycle(g, rdy);
      chk("t4_start_ready", rdy, 0);
      cs = 0;
      done_cnt = 0;
      rdy_cnt = 0;
      for (int k = 1; k <= NPIX; k++) begin
         cs = (k == 100);
         cycle(g, rdy);
         if (rdy != 0) rdy_cnt++;
         if (clear_done) done_cnt++;
         if (k == 1)    begin chk("t4_p00x", vga_x, 0);   chk("t4_p00y", vga_y, 0);   end
         if (k == 160)  begin chk("t4_p159x", vga_x, 159); chk("t4_p159y", vga_y, 0); end
         if (k == 161)  begin chk("t4_p01x", vga_x, 0);   chk("t4_p01y", vga_y, 1);   end
         if (k == NPIX) begin
            chk("t4_lastx", vga_x, 159); chk("t4_lasty", vga_y, 119);
            chk("t4_lastcol", vga_colour, 0);
         end
      end
      cs = 0;
      chk("t4_ready_cnt", rdy_cnt, 0);
      chk("t4_done_cnt", done_cnt, 1);
      cycle(g, rdy);
      chk("t4_resume", rdy, 2);

      // test 5: out-of-range pixels accepted but dropped
      set_req(1, 0, 0, 0, 0);
      set_req(0, 1, 160, 5, 2);
      cycle(g, rdy);
      chk("t5a_ready", rdy, 1);
      chk("t5a_plot", vga_plot, 0);
      set_req(0, 1, 5, 120, 2);
      cycle(g, rdy);
      chk("t5b_ready", rdy, 1);
      chk("t5b_plot", vga_plot, 0);

      random_run(1500);

      // test 6: reset part way through a clear, then a fresh sweep
      cs = 1;
      cycle(g, rdy);
      cs = 0;
      for (int k = 0; k < 5000; k++) cycle(g, rdy);
      chk("t6_busy_pre", clear_busy, 1);
      @(negedge clk);
      #2 reset = 1'b1;
      #1;
      chk("t6_busy", clear_busy, 0);
      chk("t6_plot", vga_plot, 0);
      @(posedge clk);
      #1 reset = 1'b0;
      model_reset();
      cs = 1;
      cycle(g, rdy);
      cs = 0;
      cycle(g, rdy);
      chk("t6_x0", vga_x, 0);
      chk("t6_y0", vga_y, 0);
      chk("t6_plot0", vga_plot, 1);
      for (int k = 0; k < 200; k++) cycle(g, rdy);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
